// File: rtl/pwm_encoder_if.sv
// Duty-value handshake into the PWM encoder: the source (master) offers duty_in with
// duty_valid, and the encoder (slave) takes it when duty_ready is high.
interface pwm_encoder_if;
   logic [7:0] duty_in;
   logic       duty_valid;
   logic       duty_ready;

   modport master (output duty_in, output duty_valid, input  duty_ready);
   modport slave  (input  duty_in, input  duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_encoder.sv
// PWM output stage: a duty value is held, then loaded into the shadow register at
// period boundaries only. Define PWM_CENTER_ALIGNED_EN for the up/down (510-tick) counter.
module pwm_encoder #(
   parameter int PRESCALE = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   pwm_encoder_if.slave  duty_if,
   output logic          pwm_out,
   output logic          period_start,
   output logic          busy
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    cnt_q, cnt_d, cnt_nxt;
   logic [7:0]    shadow_q, shadow_d;
   logic [7:0]    hold_q, hold_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          pending_q, pending_d;
   logic          pwm_q, pwm_d;
   logic          ps_q, ps_d;
   logic          tick, boundary, accept;
`ifdef PWM_CENTER_ALIGNED_EN
   logic          down_q, down_d, down_nxt;
`endif

   always_comb begin
      accept = duty_if.duty_valid && !pending_q;
      tick   = (state_q != S_IDLE) && (presc_q == PRESC_MAX);
`ifdef PWM_CENTER_ALIGNED_EN
      boundary = tick && down_q && (cnt_q == 8'd1);
      cnt_nxt  = cnt_q;
      down_nxt = down_q;
      if (tick) begin
         if (down_q) begin
            cnt_nxt = cnt_q - 8'd1;
            if (cnt_q == 8'd1) down_nxt = 1'b0;
         end else if (cnt_q == 8'hFF) begin
            cnt_nxt  = 8'd254;
            down_nxt = 1'b1;
         end else begin
            cnt_nxt = cnt_q + 8'd1;
         end
      end
`else
      boundary = tick && (cnt_q == 8'hFF);
      cnt_nxt  = tick ? cnt_q + 8'd1 : cnt_q;
`endif
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      presc_d   = presc_q;
      shadow_d  = shadow_q;
      hold_d    = hold_q;
      pending_d = pending_q;
      pwm_d     = pwm_q;
      ps_d      = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      down_d    = down_q;
`endif
      // accept and shadow load are exclusive: both need opposite values of pending_q
      if (accept) begin
         hold_d    = duty_if.duty_in;
         pending_d = 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            cnt_d   = 8'd0;
            presc_d = '0;
            pwm_d   = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
            down_d  = 1'b0;
`endif
            if (en) begin
               state_d = S_RUN;
               ps_d    = 1'b1;
               if (pending_q) begin
                  shadow_d  = hold_q;
                  pending_d = 1'b0;
               end
            end
         end
         S_RUN, S_STOP: begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            cnt_d   = cnt_nxt;
            pwm_d   = (cnt_q < shadow_q);
`ifdef PWM_CENTER_ALIGNED_EN
            down_d  = down_nxt;
`endif
            if (boundary && pending_q) begin
               shadow_d  = hold_q;
               pending_d = 1'b0;
            end
            if (state_q == S_RUN) begin
               ps_d = boundary;
               if (!en) state_d = S_STOP;
            end else if (en) begin
               state_d = S_RUN;
            end else if (boundary) begin
               // stopping only at a boundary keeps the last period whole
               state_d = S_IDLE;
               cnt_d   = 8'd0;
               presc_d = '0;
               pwm_d   = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
               down_d  = 1'b0;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         presc_q   <= '0;
         shadow_q  <= 8'd0;
         hold_q    <= 8'd0;
         pending_q <= 1'b0;
         pwm_q     <= 1'b0;
         ps_q      <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
         down_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         presc_q   <= presc_d;
         shadow_q  <= shadow_d;
         hold_q    <= hold_d;
         pending_q <= pending_d;
         pwm_q     <= pwm_d;
         ps_q      <= ps_d;
`ifdef PWM_CENTER_ALIGNED_EN
         down_q    <= down_d;
`endif
      end
   end

   assign duty_if.duty_ready = ~pending_q;
   assign pwm_out            = pwm_q;
   assign period_start       = ps_q;
   assign busy               = (state_q != S_IDLE);

endmodule

// File: tb/tb_pwm_encoder.sv
// Directed bench for pwm_encoder: one PRESCALE=1 instance for the main sequence and a
// PRESCALE=4 instance for period scaling; expectations follow PWM_CENTER_ALIGNED_EN.
module tb_pwm_encoder;
`ifdef PWM_CENTER_ALIGNED_EN
   localparam int PER = 510;
`else
   localparam int PER = 256;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic en4 = 1'b0;
   logic pwm, ps, busy, pwm4, ps4, busy4;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pwm_encoder_if din ();
   pwm_encoder_if din4 ();

   pwm_encoder #(.PRESCALE(1)) dut (
      .clk(clk), .rst(rst), .en(en), .duty_if(din),
      .pwm_out(pwm), .period_start(ps), .busy(busy));

   pwm_encoder #(.PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .en(en4), .duty_if(din4),
      .pwm_out(pwm4), .period_start(ps4), .busy(busy4));

   function automatic int hi_of(input int d);
`ifdef PWM_CENTER_ALIGNED_EN
      return (d == 0) ? 0 : 2 * d - 1;
`else
      return d;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   // One full period starting just after a boundary edge; optionally writes a new duty
   // at step wr_at, which must stay pending until the closing boundary.
   task automatic run_period(input int wr_at, input int wr_val, input int exp_hi, input string tag);
      int hi = 0;
      int npst = 0;
      for (int i = 1; i <= PER; i++) begin
         step();
         if (pwm) hi++;
         if (ps) npst++;
         if (i == wr_at) begin
            din.duty_in    = 8'(wr_val);
            din.duty_valid = 1'b1;
         end
         if (wr_at > 0 && i == wr_at + 1) begin
            chk({tag, "_rdy_after_wr"}, din.duty_ready, 0);
            din.duty_valid = 1'b0;
         end
         if (wr_at > 0 && i == PER - 1) chk({tag, "_rdy_before_bnd"}, din.duty_ready, 0);
         if (wr_at > 0 && i == PER)     chk({tag, "_rdy_after_bnd"}, din.duty_ready, 1);
      end
      chk({tag, "_high"}, hi, exp_hi);
      chk({tag, "_pstart_cnt"}, npst, 1);
      chk({tag, "_pstart_at_bnd"}, ps, 1);
   endtask

   initial begin
      int n, extra, hi;
      din.duty_in     = 8'd0;
      din.duty_valid  = 1'b0;
      din4.duty_in    = 8'd0;
      din4.duty_valid = 1'b0;

      // reset state
      #1 rst = 1'b0;
      #1;
      chk("rst_pwm", pwm, 0);
      chk("rst_ps", ps, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", din.duty_ready, 1);
      step();
      rst = 1'b1;

      // write while idle: stays pending
      din.duty_in    = 8'd64;
      din.duty_valid = 1'b1;
      step();
      din.duty_valid = 1'b0;
      chk("idle_wr_ready", din.duty_ready, 0);
      steps(5);
      chk("idle_busy", busy, 0);
      chk("idle_pwm", pwm, 0);
      chk("idle_ps", ps, 0);
      chk("idle_still_pending", din.duty_ready, 0);

      // start: entry pulse and pending duty loaded
      en = 1'b1;
      step();
      chk("entry_ps", ps, 1);
      chk("entry_busy", busy, 1);
      chk("entry_ready", din.duty_ready, 1);
      run_period(-1, 0, hi_of(64), "p64");

      // mid-period update waits for the boundary
      run_period(100, 200, hi_of(64), "wr200");
      run_period(-1, 0, hi_of(200), "p200");

      // duty 0 for three periods, then duty 255
      run_period(10, 0, hi_of(200), "wr0");
      run_period(-1, 0, 0, "d0_a");
      run_period(-1, 0, 0, "d0_b");
      run_period(10, 255, 0, "d0_c");
      run_period(-1, 0, hi_of(255), "p255");

      // stop mid-period: finishes the period, then idle with no extra pulse
      steps(100);
      en = 1'b0;
      n = 0;
      extra = 0;
      while (busy && n < 2 * PER) begin
         step();
         n++;
         if (ps) extra++;
      end
      chk("stop_len", n, PER - 100);
      chk("stop_no_pstart", extra, 0);
      chk("stop_pwm", pwm, 0);
      steps(3);
      chk("stop_stays_idle", busy, 0);

      // stop then resume before the boundary: no restart
      en = 1'b1;
      step();
      chk("rerun_entry_ps", ps, 1);
      steps(100);
      en = 1'b0;
      steps(50);
      en = 1'b1;
      n = 0;
      extra = 0;
      while (!ps && n < 2 * PER) begin
         step();
         n++;
         if (!busy) extra++;
      end
      chk("resume_len", n, PER - 150);
      chk("resume_busy_kept", extra, 0);

      // reset mid-period with pwm high and a duty pending
      steps(5);
      din.duty_in    = 8'd77;
      din.duty_valid = 1'b1;
      step();
      din.duty_valid = 1'b0;
      chk("pend77_ready", din.duty_ready, 0);
      steps(34);
      chk("pre_rst_pwm", pwm, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_pwm", pwm, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ps", ps, 0);
      chk("mid_rst_ready", din.duty_ready, 1);
      en = 1'b0;
      step();
      rst = 1'b1;
      en  = 1'b1;
      step();
      chk("post_rst_entry_ps", ps, 1);
      run_period(-1, 0, 0, "post_rst_lost");

      // PRESCALE=4 instance: four clocks per tick
      din4.duty_in    = 8'd128;
      din4.duty_valid = 1'b1;
      step();
      din4.duty_valid = 1'b0;
      chk("p4_wr_ready", din4.duty_ready, 0);
      en4 = 1'b1;
      step();
      chk("p4_entry_ps", ps4, 1);
      chk("p4_entry_busy", busy4, 1);
      n  = 0;
      hi = 0;
      do begin
         step();
         n++;
         if (pwm4) hi++;
      end while (!ps4 && n < 8 * PER);
      chk("p4_period", n, 4 * PER);
      chk("p4_high", hi, 4 * hi_of(128));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
